booth_mult_scheduler: RTL and testbench
=======================================

BOOTH_MULT_SCHEDULER -- requirements
Module: booth_mult_scheduler

Interface
REQ-001 SHALL have parameter N_ITER, default 4, giving the multiplier operand width and the number of Booth iterations; only the value 4 is required.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 has an operand pair pending.
REQ-005 SHALL have ports req0_a and req0_b, input, 4 bits each, signed: requester 0 multiplier and multiplicand.
REQ-006 SHALL have port req0_ready, output, 1 bit: requester 0 operands are accepted this cycle.
REQ-007 SHALL have ports req1_valid (input, 1), req1_a and req1_b (input, 4 bits each, signed) and req1_ready (output, 1), with the same meanings for requester 1.
REQ-008 SHALL have port prod, output, 8 bits, signed: the product result.
REQ-009 SHALL have port prod_valid, output, 1 bit: a one-cycle pulse marking a new result.
REQ-010 SHALL have port prod_id, output, 1 bit: the index of the requester that owns prod.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, ITER and DONE.
REQ-013 In IDLE, req0_ready and req1_ready SHALL be driven combinationally; they are high only for the arbitration winner, and only while that requester's valid is high.
- Acceptance = valid && ready.
REQ-014 Arbitration SHALL be round-robin.
- Single valid requester: it wins.
- Both valid: the requester not granted last wins.
- Pointer reset value: requester 0 is preferred.
REQ-015 On acceptance, the FSM SHALL:
- capture A and B;
- clear the accumulator;
- clear the Booth bit e;
- clear the iteration counter;
- record the winner's id;
- update the round-robin pointer;
- move to ITER.
REQ-016 In ITER, each cycle SHALL perform one radix-2 Booth step on bit i of A:
- {A[i],e}=10: upper partial sum minus B;
- {A[i],e}=01: upper partial sum plus B;
- 00 or 11: no change;
- then arithmetic right shift by 1 (sign bit replicated);
- then e <= A[i].
REQ-017 The upper partial sum SHALL be 5 bits, with B sign-extended, so that B = -8 yields exact results.
REQ-018 Intermediate results SHALL never wrap.
REQ-019 After exactly N_ITER ITER cycles, the FSM SHALL move to DONE.
REQ-020 In DONE, the block SHALL load prod and prod_id, assert prod_valid for exactly one cycle, then return to IDLE.
REQ-021 prod SHALL equal the exact signed product A*B for all 256 operand pairs.
REQ-022 prod and prod_id SHALL hold their values until the next DONE.
REQ-023 Latency: acceptance in cycle T SHALL give prod_valid in cycle T+5; the earliest next acceptance is T+6.
REQ-024 ready SHALL be low for both requesters in ITER and DONE; valid raised during these states waits and is not lost.
REQ-025 Operand inputs SHALL be ignored after capture; changes during ITER have no effect.
REQ-026 The result port SHALL have no backpressure; prod_valid is not gated by any input.
REQ-027 A requester that drops valid before acceptance SHALL be treated as not requesting.

Reset
REQ-028 While rst_n=0 at a rising edge, the following SHALL be forced:
- state=IDLE;
- prod=0, prod_id=0, prod_valid=0;
- busy=0;
- round-robin pointer preferring requester 0;
- accumulator, e and counter=0.
REQ-029 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-030 Reset asserted mid-ITER or in DONE SHALL abort the operation.
- No prod_valid pulse for the aborted operation.
- The aborted operation is not retried.
REQ-031 The first acceptance SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-032 Basic product: req0 a=3, b=5 alone -> req0_ready=1 in cycle T; prod=8'h0F, prod_id=0, prod_valid pulse at T+5.
REQ-033 Extremes and negatives:
- a=-8, b=-8 -> prod=8'h40 (64);
- a=-8, b=7 -> prod=8'hC8 (-56);
- a=-1, b=-1 -> prod=8'h01.
REQ-034 Contention after reset: both valid with req0 (2,-3) and req1 (-4,6) -> req0 served first, prod=8'hFA with id=0; then req1, prod=8'hE8 with id=1; second acceptance 6 cycles after the first.
REQ-035 Fairness: both valid continuously -> grants strictly alternate 0,1,0,1; busy low for exactly one cycle between operations.
REQ-036 Abort: rst_n=0 for one cycle during the 2nd ITER cycle -> no prod_valid, outputs zero; a new request is accepted in the next cycle.
REQ-037 Exhaustive: all 256 (a,b) pairs through each requester -> every prod matches the reference signed product.

Source files
------------

// File: rtl/booth_mult_scheduler.sv
// Two-requester front end for a radix-2 Booth multiplier: round-robin grant in IDLE,
// then N_ITER Booth steps and a one-cycle result pulse.
module booth_mult_scheduler #(
  parameter int N_ITER = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic signed [N_ITER-1:0]   req0_a,
  input  logic signed [N_ITER-1:0]   req0_b,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic signed [N_ITER-1:0]   req1_a,
  input  logic signed [N_ITER-1:0]   req1_b,
  output logic                       req1_ready,
  output logic signed [2*N_ITER-1:0] prod,
  output logic                       prod_valid,
  output logic                       prod_id,
  output logic                       busy
);

  localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [N_ITER-1:0]     a_reg, a_next;
  logic [N_ITER-1:0]     b_reg, b_next;
  logic [N_ITER:0]       hi_reg, hi_next;
  logic [N_ITER-1:0]     lo_reg, lo_next;
  logic                  e_reg, e_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  id_reg, id_next;
  logic                  pri_reg, pri_next;
  logic [2*N_ITER-1:0]   prod_reg, prod_next;
  logic                  prod_id_reg, prod_id_next;

  logic [1:0]            valid_vec;
  logic [1:0]            ready_vec;
  logic [N_ITER-1:0]     a_vec [2];
  logic [N_ITER-1:0]     b_vec [2];
  logic                  winner;
  logic                  accept;

  logic                  booth_bit;
  logic [N_ITER:0]       b_ext;
  logic [N_ITER:0]       sum;
  logic [N_ITER:0]       hi_shift;
  logic [N_ITER-1:0]     lo_shift;

  assign valid_vec = {req1_valid, req0_valid};
  assign a_vec[0]  = req0_a;
  assign a_vec[1]  = req1_a;
  assign b_vec[0]  = req0_b;
  assign b_vec[1]  = req1_b;

  // pri_reg names the requester that wins a tie; it flips to the loser on every grant.
  assign winner = valid_vec[1] & (~valid_vec[0] | pri_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n && (state_reg == IDLE) && valid_vec[gi] && (winner == 1'(gi));
    end
  endgenerate

  assign accept     = |ready_vec;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // One Booth step on the sign-extended upper partial sum, then arithmetic shift of {hi,lo}.
  always_comb begin
    booth_bit = a_reg[cnt_reg];
    b_ext     = {b_reg[N_ITER-1], b_reg};
    sum       = hi_reg;
    case ({booth_bit, e_reg})
      2'b10:   sum = hi_reg - b_ext;
      2'b01:   sum = hi_reg + b_ext;
      default: sum = hi_reg;
    endcase
    hi_shift = {sum[N_ITER], sum[N_ITER:1]};
    lo_shift = {sum[0], lo_reg[N_ITER-1:1]};
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    e_next       = e_reg;
    cnt_next     = cnt_reg;
    id_next      = id_reg;
    pri_next     = pri_reg;
    prod_next    = prod_reg;
    prod_id_next = prod_id_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = a_vec[winner];
          b_next     = b_vec[winner];
          hi_next    = '0;
          lo_next    = '0;
          e_next     = 1'b0;
          cnt_next   = '0;
          id_next    = winner;
          pri_next   = ~winner;
          state_next = ITER;
        end
      end
      ITER: begin
        hi_next  = hi_shift;
        lo_next  = lo_shift;
        e_next   = booth_bit;
        cnt_next = cnt_reg + 1'b1;
        // Result is registered on the last step so it is already on prod during DONE.
        if (cnt_reg == CW'(N_ITER - 1)) begin
          prod_next    = {hi_shift[N_ITER-1:0], lo_shift};
          prod_id_next = id_reg;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      e_reg       <= 1'b0;
      cnt_reg     <= '0;
      id_reg      <= 1'b0;
      pri_reg     <= 1'b0;
      prod_reg    <= '0;
      prod_id_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      e_reg       <= e_next;
      cnt_reg     <= cnt_next;
      id_reg      <= id_next;
      pri_reg     <= pri_next;
      prod_reg    <= prod_next;
      prod_id_reg <= prod_id_next;
    end
  end

  assign prod       = prod_reg;
  assign prod_id    = prod_id_reg;
  assign prod_valid = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Randomized and directed bench; a cycle-level scheduling model predicts grants,
// result timing, held outputs and busy from the arbitration and latency rules.
module tb_booth_mult_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic [3:0] req0_a = '0;
  logic [3:0] req0_b = '0;
  logic [3:0] req1_a = '0;
  logic [3:0] req1_b = '0;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] prod;
  logic       prod_valid;
  logic       prod_id;
  logic       busy;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  booth_mult_scheduler #(.N_ITER(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_id    (prod_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 8'(sa * sb);
  endfunction

  // Reference model state
  typedef struct {
    int         due;
    logic       id;
    logic [7:0] p;
  } exp_t;

  exp_t       pend[$];
  int         cyc = 0;
  int         next_free = 0;
  int         acc_cycle = -100;
  int         w;
  logic       last_grant = 1'b1;
  logic       exp_pv;
  logic       exp_busy;
  logic [7:0] exp_prod = '0;
  logic       exp_id = 1'b0;
  logic       acc_seen [2] = '{1'b0, 1'b0};

  initial begin
    forever begin
      @(negedge clk);
      if (req0_valid && req0_ready) acc_seen[0] = 1'b1;
      if (req1_valid && req1_ready) acc_seen[1] = 1'b1;
      if (!rst_n) begin
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        pend.delete();
        next_free  = cyc + 1;
        last_grant = 1'b1;
        acc_cycle  = -100;
        exp_prod   = '0;
        exp_id     = 1'b0;
      end else begin
        exp_pv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          exp_pv   = 1'b1;
          exp_prod = pend[0].p;
          exp_id   = pend[0].id;
          void'(pend.pop_front());
        end
        exp_busy = (cyc > acc_cycle) && (cyc <= acc_cycle + 5);
        chk("prod_valid", 32'(prod_valid), 32'(exp_pv));
        chk("prod",       32'(prod),       32'(exp_prod));
        chk("prod_id",    32'(prod_id),    32'(exp_id));
        chk("busy",       32'(busy),       32'(exp_busy));
        w = -1;
        if (cyc >= next_free) begin
          if (req0_valid && req1_valid) w = (last_grant == 1'b0) ? 1 : 0;
          else if (req1_valid)          w = 1;
          else if (req0_valid)          w = 0;
        end
        chk("req0_ready", 32'(req0_ready), 32'(w == 0));
        chk("req1_ready", 32'(req1_ready), 32'(w == 1));
        if (w == 0) pend.push_back('{due: cyc + 5, id: 1'b0, p: ref_mul(req0_a, req0_b)});
        if (w == 1) pend.push_back('{due: cyc + 5, id: 1'b1, p: ref_mul(req1_a, req1_b)});
        if (w >= 0) begin
          $display("[TB] cyc %0d grant req%0d", cyc, w);
          last_grant = 1'(w);
          next_free  = cyc + 6;
          acc_cycle  = cyc;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input int r, input logic v, input logic [3:0] a, input logic [3:0] b);
    if (r == 0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  task automatic wait_acc(input int r);
    int n;
    n = 0;
    while (!acc_seen[r] && n < 30) begin
      tick();
      n++;
    end
    if (!acc_seen[r]) chk("acc_timeout", 32'd0, 32'd1);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic send(input int r, input logic [3:0] a, input logic [3:0] b);
    acc_seen[r] = 1'b0;
    drive(r, 1'b1, a, b);
    wait_acc(r);
  endtask

  task automatic send_pair(input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] a1, input logic [3:0] b1);
    int n;
    acc_seen[0] = 1'b0;
    acc_seen[1] = 1'b0;
    drive(0, 1'b1, a0, b0);
    drive(1, 1'b1, a1, b1);
    n = 0;
    while (!(acc_seen[0] && acc_seen[1]) && n < 40) begin
      tick();
      if (acc_seen[0]) req0_valid = 1'b0;
      if (acc_seen[1]) req1_valid = 1'b0;
      n++;
    end
    if (!(acc_seen[0] && acc_seen[1])) chk("pair_timeout", 32'd0, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Accept in the very first cycle out of reset, then signed extremes.
    do_reset(3);
    send(0, 4'd3, 4'd5);
    send(0, 4'h8, 4'h8);
    send(0, 4'h8, 4'h7);
    send(0, 4'hF, 4'hF);
    repeat (8) tick();

    // Contention straight after reset: requester 0 is preferred.
    do_reset(2);
    send_pair(4'd2, 4'hD, 4'hC, 4'd6);
    repeat (8) tick();

    // Both requesters continuously valid with operands changing every cycle.
    for (int i = 0; i < 60; i++) begin
      drive(0, 1'b1, 4'($urandom), 4'($urandom));
      drive(1, 1'b1, 4'($urandom), 4'($urandom));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) tick();

    // Abort: one reset cycle in the second ITER cycle, with requester 1 waiting.
    acc_seen[0] = 1'b0;
    drive(0, 1'b1, 4'd5, 4'd9);
    wait_acc(0);
    tick();
    rst_n = 1'b0;
    acc_seen[1] = 1'b0;
    drive(1, 1'b1, 4'd6, 4'd3);
    tick();
    rst_n = 1'b1;
    wait_acc(1);
    repeat (8) tick();

    // Exhaustive operand sweep through each requester.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) begin
        send(r, 4'(i), 4'(i >> 4));
      end
    end
    repeat (8) tick();

    // Random traffic with valids dropping freely and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      drive(0, 1'($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom));
      drive(1, 1'($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom));
      tick();
    end
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (12) tick();
    chk("drain_empty", 32'(pend.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
